// File: rtl/inst_b_enc.sv
// RV32I B-type instruction encoder: packs branch fields into a 32-bit word,
// flags illegal requests and buffers results in a small output FIFO.
module inst_b_enc #(
  parameter int          DEPTH  = 2,
  parameter logic [6:0]  OPCODE = 7'b1100011,
  parameter int          CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       offset,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instruction_word,
  output logic              out_err,
  output logic [CNT_W-1:0]  enc_count,
  output logic [7:0]        err_count
);

  localparam int         PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [31:0]      word_mem [DEPTH];
  logic [DEPTH-1:0] err_mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [31:0]      last_word;
  logic             last_err;

  logic        push;
  logic        pop;
  logic [31:0] enc_word;
  logic        enc_err;

  always_comb begin
    enc_word = {offset[12], offset[10:5], rs2, rs1, funct3,
                offset[4:1], offset[11], OPCODE};
    enc_err  = (funct3 == 3'b010) || (funct3 == 3'b011) || offset[0];
  end

  // in_ready depends only on occupancy, so a full FIFO never passes through.
  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // When empty the head slot is stale, so show the last popped entry instead.
  assign instruction_word = out_valid ? word_mem[rd_ptr] : last_word;
  assign out_err          = out_valid ? err_mem[rd_ptr]  : last_err;

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr] <= enc_word;
      err_mem[wr_ptr]  <= enc_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_word <= '0;
      last_err  <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (enc_err) begin
          if (err_count != '1)
            err_count <= err_count + 8'd1;
        end else begin
          enc_count <= enc_count + CNT_W'(1);
        end
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        last_word <= word_mem[rd_ptr];
        last_err  <= err_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_b_enc.sv
// Bench for inst_b_enc: queue-based reference model, per-cycle compare,
// directed literal checks and randomized traffic with random backpressure.
module tb_inst_b_enc;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [12:0] offset = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instruction_word;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  inst_b_enc #(.DEPTH(DEPTH), .OPCODE(7'b1100011), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .offset(offset),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruction_word(instruction_word), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference encoding straight from the field layout, using integer arithmetic.
  function automatic logic [32:0] model_enc(input int unsigned f3, input int unsigned a,
                                            input int unsigned b, input int unsigned imm);
    int unsigned w;
    bit e;
    w = (((imm >> 12) & 1) << 31) + (((imm >> 5) & 63) << 25) + (b << 20) + (a << 15)
      + (f3 << 12) + (((imm >> 1) & 15) << 8) + (((imm >> 11) & 1) << 7) + 32'h63;
    e = (f3 == 2) || (f3 == 3) || ((imm & 1) == 1);
    return {e, w[31:0]};
  endfunction

  logic [32:0] mq[$];
  logic [31:0] m_last_w;
  logic        m_last_e;
  logic [15:0] m_enc;
  logic [7:0]  m_err;
  logic [32:0] m_new;
  bit          m_acc;
  bit          m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_last_w = '0;
      m_last_e = 1'b0;
      m_enc    = '0;
      m_err    = '0;
    end else begin
      m_acc = in_valid && (mq.size() < DEPTH);
      m_pop = out_ready && (mq.size() > 0);
      if (m_pop) {m_last_e, m_last_w} = mq.pop_front();
      if (m_acc) begin
        m_new = model_enc(funct3, rs1, rs2, offset);
        mq.push_back(m_new);
        if (m_new[32]) m_err = (m_err == 8'd255) ? m_err : m_err + 8'd1;
        else           m_enc = m_enc + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
      chk("word", 64'(instruction_word), 64'((mq.size() != 0) ? mq[0][31:0] : m_last_w));
      chk("err",  64'(out_err),          64'((mq.size() != 0) ? mq[0][32]   : m_last_e));
      chk("enc_count", 64'(enc_count), 64'(m_enc));
      chk("err_count", 64'(err_count), 64'(m_err));
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  // Called in the high phase after an edge; holds the request until accepted.
  task automatic push(input logic [2:0] f, input logic [4:0] a, input logic [4:0] b,
                      input logic [12:0] o);
    int unsigned n;
    bit acc;
    n = 0;
    acc = 1'b0;
    funct3 = f; rs1 = a; rs2 = b; offset = o; in_valid = 1'b1;
    while (!acc && n < 50) begin
      acc = in_ready;
      @(posedge clk);
      #2;
      n++;
    end
    if (!acc) chk("push_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  bit rnd_done;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_word", 64'(instruction_word), 64'(0));
    chk("rst_enc", 64'(enc_count), 64'(0));
    chk("rst_err", 64'(err_count), 64'(0));
    @(posedge clk); #3 rst_n = 1'b1;
    chk_en = 1'b1;
    sync();

    // Directed legal/illegal encodes with a consumer always ready.
    out_ready = 1'b1;
    push(3'b000, 5'd1, 5'd2, 13'd8);
    @(negedge clk);
    chk("lit_valid1", 64'(out_valid), 64'(1));
    chk("lit_word1", 64'(instruction_word), 64'h0020_8463);
    chk("lit_err1", 64'(out_err), 64'(0));
    chk("lit_enc1", 64'(enc_count), 64'(1));
    sync();
    push(3'b001, 5'd5, 5'd6, 13'h1FFC);
    @(negedge clk);
    chk("lit_word2", 64'(instruction_word), 64'hFE62_9EE3);
    chk("lit_err2", 64'(out_err), 64'(0));
    sync();
    push(3'b010, 5'd1, 5'd2, 13'd8);
    @(negedge clk);
    chk("lit_word3", 64'(instruction_word), 64'h0020_A463);
    chk("lit_err3", 64'(out_err), 64'(1));
    chk("lit_errcnt3", 64'(err_count), 64'(1));
    chk("lit_enc3", 64'(enc_count), 64'(2));
    sync();
    push(3'b000, 5'd0, 5'd0, 13'h005);
    @(negedge clk);
    chk("lit_word4", 64'(instruction_word), 64'h0000_0263);
    chk("lit_err4", 64'(out_err), 64'(1));
    sync();
    sync();
    chk("lit_hold_empty", 64'(instruction_word), 64'h0000_0263);

    // Backpressure: two accepts fill the FIFO, the third waits for a pop.
    out_ready = 1'b0;
    fork
      begin
        push(3'b100, 5'd3, 5'd4, 13'd16);
        push(3'b101, 5'd7, 5'd8, 13'd32);
        push(3'b110, 5'd9, 5'd10, 13'h1FF0);
      end
      begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_head", 64'(instruction_word),
            64'(model_enc(4, 3, 4, 16) & 33'h0_FFFF_FFFF));
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    repeat (4) sync();

    // Randomized traffic with random consumer stalls.
    rnd_done = 1'b0;
    fork
      begin
        for (int unsigned i = 0; i < 400; i++) begin
          logic [12:0] o;
          o = 13'($urandom);
          if ($urandom_range(0, 3) != 0) o[0] = 1'b0;
          push(3'($urandom), 5'($urandom), 5'($urandom), o);
          if ($urandom_range(0, 3) == 0) sync();
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          sync();
        end
      end
    join
    out_ready = 1'b1;
    repeat (4) sync();

    // Asynchronous reset with entries queued.
    out_ready = 1'b0;
    push(3'b000, 5'd1, 5'd1, 13'd4);
    push(3'b111, 5'd2, 5'd2, 13'd6);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_enc", 64'(enc_count), 64'(0));
    chk("arst_err", 64'(err_count), 64'(0));
    chk("arst_word", 64'(instruction_word), 64'(0));
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    sync();
    out_ready = 1'b1;
    push(3'b000, 5'd1, 5'd2, 13'd8);
    @(negedge clk);
    chk("arst_after_word", 64'(instruction_word), 64'h0020_8463);
    chk("arst_after_enc", 64'(enc_count), 64'(1));
    repeat (3) sync();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_b_enc.md
Name: inst_b_enc

Overview:
- Sequential RV32I B-type instruction encoder, the inverse of the B-type field decoder.
- Accepts branch fields (funct3, rs1, rs2, signed byte offset) over a valid/ready handshake.
- Packs them into a 32-bit instruction word and buffers the result in a small output FIFO.
- Flags illegal requests and keeps encode/error statistics; feeds instruction-memory preload and self-checking benches.

Parameters:
- DEPTH, 2, output FIFO entries (power of 2, >= 2).
- OPCODE, 7'b1100011, value placed in instruction_word[6:0].
- CNT_W, 16, width of enc_count.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept.
- funct3  in  3  branch condition.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- offset  in  13  signed byte offset (imm[12:0]).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- instruction_word  out  32  encoded word at FIFO head.
- out_err  out  1  error flag of head entry.
- enc_count  out  CNT_W  legal words accepted (wraps).
- err_count  out  8  illegal requests accepted (saturates at 255).

Behaviour:
- Reset (rst_n low, async): FIFO emptied; out_valid=0; instruction_word=0; out_err=0; enc_count=0; err_count=0; in_ready=1 once released. Reset mid-operation discards all buffered entries.
- Accept: in_valid & in_ready at a rising edge. Pop: out_valid & out_ready at a rising edge.
- Encoding, computed combinationally on accept, stored in FIFO:
  - [31]=offset[12]
  - [30:25]=offset[10:5]
  - [24:20]=rs2
  - [19:15]=rs1
  - [14:12]=funct3
  - [11:8]=offset[4:1]
  - [7]=offset[11]
  - [6:0]=OPCODE
  - offset[0] never encoded.
- Error: err=1 when funct3 is 010 or 011, or offset[0]=1.
  - Erroneous requests are still encoded and queued, with out_err=1.
  - err_count += 1 (saturating); enc_count unchanged.
  - Legal requests: enc_count += 1, wrapping.
- Latency: accepted at edge N → visible at head after edge N when FIFO was empty (out_valid high in cycle N+1). Order strictly FIFO.
- in_ready = (count < DEPTH). When full, no same-cycle pass-through: in_ready stays 0 even if out_ready=1 that cycle.
- Simultaneous push and pop when not full and not empty: count unchanged, both take effect.
- Empty: out_valid=0; instruction_word and out_err hold their last popped value (0 after reset).
- Output stability: while out_valid=1 and out_ready=0, instruction_word and out_err hold stable.
- Pointers wrap modulo DEPTH; count is 0..DEPTH.

Test Plan:
- Legal encodes, out_ready=1:
  - funct3=000, rs1=1, rs2=2, offset=+8 → next cycle out_valid=1, instruction_word=0x00208463, out_err=0, enc_count=1.
  - funct3=001, rs1=5, rs2=6, offset=-4 (13'h1FFC) → 0xFE629EE3, out_err=0.
- Illegal funct3: funct3=010, rs1=1, rs2=2, offset=8 → word 0x0020A463, out_err=1, err_count=1, enc_count unchanged.
- Odd offset: funct3=000, rs1=0, rs2=0, offset=13'h005 → word 0x00000263, out_err=1.
- Backpressure: out_ready=0, three back-to-back requests:
  - in_ready drops after 2 accepts; third is held.
  - Then out_ready=1: words emerge in order; third accepted one cycle after the first pop; no loss or duplication.
- Reset mid-operation: 2 entries queued, pulse rst_n low asynchronously (between edges) → out_valid=0, enc_count=0, err_count=0 immediately; in_ready=1 after release.
